instruction_fetch: RTL

//   Fetch stage directly upstream of instruction_decoder. Holds the PC, issues in-order

---
 rtl/instruction_fetch.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, issues in-order word requests to instruction
// memory, and buffers returned words for the decoder. A redirect reloads the
// PC, clears the buffer and drops every response still in flight.
//
// Handshakes:
//   imem_req/imem_gnt : a request transfers in a cycle where both are high.
//   imem_rvalid       : one response per transferred request, in order.
//   id_valid/id_ready : a word transfers to the decoder in a cycle where both
//                       are high; id_valid never depends on id_ready.
`timescale 1ns/1ps

module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  // instruction memory side
  output logic                                imem_req,
  output logic [31:0]                         imem_addr,
  input  logic                                imem_gnt,
  input  logic                                imem_rvalid,
  input  logic [31:0]                         imem_rdata,
  // control flow change
  input  logic                                redirect_valid,
  input  logic [31:0]                         redirect_pc,
  // decoder side
  output logic                                id_valid,
  output logic [31:0]                         id_instr,
  output logic [31:0]                         id_pc,
  input  logic                                id_ready,
  // debug view of the flush FSM
  output logic                                dbg_flush,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     dbg_discard
);

  // Counters hold 0..FIFO_DEPTH; pointers index FIFO_DEPTH entries.
  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e        state_q;
  logic [CW-1:0] disc_q;
  logic [CW-1:0] disc_redir;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [PW-1:0] rd_q, wr_q;

  logic [31:0]   tag_q [FIFO_DEPTH];
  logic [PW-1:0] tag_rd_q, tag_wr_q;

  logic          credit_ok;
  logic          grant;
  logic          rsp;
  logic          push;
  logic          pop;
  logic [31:0]   redir_target;

  // Circular pointer increment that also works for non power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // Low two bits of the redirect target are forced to zero.
  assign redir_target = redirect_pc & ~32'h0000_0003;

  // Every in-flight request must have a guaranteed FIFO slot; a pop in the
  // same cycle does not free credit because registered counts are used.
  assign credit_ok = ({1'b0, out_q} + {1'b0, cnt_q}) < {1'b0, DEPTH_C};

  assign imem_req  = rst_n & (state_q == ST_FETCH) & ~redirect_valid & credit_ok;
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;

  // A response is only accepted while something is actually outstanding.
  assign rsp  = imem_rvalid & (out_q != '0);
  assign push = rsp & (disc_q == '0) & ~redirect_valid;
  assign pop  = id_valid & id_ready;

  // Responses still owed after this edge become garbage on a redirect.
  assign disc_redir = out_q - CW'(rsp);

  assign id_valid = (cnt_q != '0);
  assign id_instr = id_valid ? fifo_instr_q[rd_q] : '0;
  assign id_pc    = id_valid ? fifo_pc_q[rd_q]    : '0;

  assign dbg_flush   = (state_q == ST_FLUSH);
  assign dbg_discard = disc_q;

  // Next-state values for PC, outstanding-request count and buffer occupancy.
  always_comb begin
    pc_d  = pc_q;
    out_d = out_q + CW'(grant) - CW'(rsp);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (redirect_valid) begin
      pc_d  = redir_target;
      cnt_d = '0;
    end else if (grant) begin
      pc_d  = pc_q + 32'd4;
    end
  end

  // PC and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      out_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  // Flush FSM: redirect wins; FLUSH drops responses until none remain owed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      disc_q  <= '0;
    end else if (redirect_valid) begin
      disc_q  <= disc_redir;
      state_q <= (disc_redir != '0) ? ST_FLUSH : ST_FETCH;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (disc_q == '0) begin
            state_q <= ST_FETCH;
          end else if (rsp) begin
            disc_q <= disc_q - CW'(1);
          end
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  // PC tag queue: one entry per granted request, consumed by its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_rd_q <= '0;
      tag_wr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (grant) begin
        tag_q[tag_wr_q] <= pc_q;
        tag_wr_q        <= ptr_inc(tag_wr_q);
      end
      if (rsp) begin
        tag_rd_q <= ptr_inc(tag_rd_q);
      end
    end
  end

  // Instruction buffer towards the decoder; cleared wholesale on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (redirect_valid) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      if (push) begin
        fifo_instr_q[wr_q] <= imem_rdata;
        fifo_pc_q[wr_q]    <= tag_q[tag_rd_q];
        wr_q               <= ptr_inc(wr_q);
      end
      if (pop) begin
        rd_q <= ptr_inc(rd_q);
      end
    end
  end

endmodule
